// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART byte transmitter
//
// Purpose: accepts one byte at a time from NUM_REQ sources (round-robin,
// last-served gets lowest priority), launches it with a one-cycle tx_start
// pulse, then follows tx_busy until the frame completes. A launch that never
// sees tx_busy rise within ACK_TIMEOUT cycles is dropped and flagged.
//
// Optional feature macro: UART_ARB_LOCK_EN (adds req_last; holds the grant
// on one requester until it sends a byte marked last).
//
// Ports:
//   clk_50m      in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   [NUM_REQ]   per-requester byte valid
//   req_data     in   [8*NUM_REQ] per-requester byte, requester i at [8*i+7:8*i]
//   req_last     in   [NUM_REQ]   (UART_ARB_LOCK_EN only) end of locked burst
//   req_ready    out  [NUM_REQ]   one-hot accept, combinational
//   tx_start     out  one-cycle launch pulse
//   tx_data      out  [8] byte held from launch until frame end
//   tx_busy      in   transmitter busy flag
//   grant_id     out  index of last accepted requester
//   active       out  high from acceptance until frame completes
//   err_timeout  out  sticky: tx_busy never rose after a launch
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_WIDTH    = 5
) (
  input  logic                       clk_50m,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_last,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err_timeout
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          data_q, data_d;
  logic [GW-1:0]       gid_q, gid_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
`ifdef UART_ARB_LOCK_EN
  logic                lock_q, lock_d;
`endif

  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] cand;
  logic          elig;
  logic          accept;

  // Winner search starts just after the last grant, so the requester served
  // most recently is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    elig      = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = GW'((int'(gid_q) + off) % NUM_REQ);
`ifdef UART_ARB_LOCK_EN
      // While locked only the owner (the last grant) may win.
      elig = !lock_q || (cand == gid_q);
`else
      elig = 1'b1;
`endif
      if (!win_found && req_valid[cand] && elig) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign accept = (state_q == S_IDLE) && !tx_busy && win_found;

  // State and datapath registers
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= 8'h00;
      gid_q   <= GW'(NUM_REQ - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef UART_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef UART_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d  = req_data[{win_idx, 3'b000} +: 8];
          gid_d   = win_idx;
          state_d = S_LAUNCH;
`ifdef UART_ARB_LOCK_EN
          lock_d  = !req_last[win_idx];
`endif
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TO_WIDTH'(ACK_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the byte, no retry.
          err_d   = 1'b1;
          state_d = S_IDLE;
`ifdef UART_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    // rst_n gates ready so nothing handshakes while reset is held.
    if (rst_n && accept) begin
      req_ready[win_idx] = 1'b1;
    end
    tx_start    = (state_q == S_LAUNCH);
    active      = (state_q != S_IDLE);
    tx_data     = data_q;
    grant_id    = gid_q;
    err_timeout = err_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ACK_TIMEOUT = 16;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [31:0]  req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_busy;
  logic [1:0]   grant_id;
  logic         active;
  logic         err_timeout;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ACK_TIMEOUT(ACK_TIMEOUT), .TO_WIDTH(5)) dut (
    .clk_50m    (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_last   (req_last),
`endif
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .active     (active),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Byte sources: per-requester FIFO of {last, data}
  logic [8:0] sbuf [4][8];
  int shead [4];
  int stail [4];
  logic [3:0] hs;

  task automatic push(int i, logic [8:0] v);
    sbuf[i][stail[i]] = v;
    stail[i]++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin shead[i] = 0; stail[i] = 0; end
    req_valid = '0; req_data = '0; req_last = '0; hs = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) shead[i]++;
        req_valid[i]        = (shead[i] < stail[i]);
        req_data[8*i +: 8]  = sbuf[i][shead[i] % 8][7:0];
        req_last[i]         = sbuf[i][shead[i] % 8][8];
      end
    end
  end

  // Transmitter: busy rises the cycle after tx_start, stays high busy_len cycles
  int   busy_len = 5;
  int   busy_left;
  logic busy_override = 1'b0;
  logic busy_force = 1'b0;
  logic start_seen = 1'b0;

  initial forever begin
    @(negedge clk);
    start_seen = tx_start;
  end

  initial begin
    tx_busy = 1'b0;
    busy_left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy_left = 0;
        tx_busy = 1'b0;
      end else if (busy_override) begin
        tx_busy = busy_force;
      end else begin
        if (start_seen) busy_left = busy_len;
        else if (busy_left > 0) busy_left--;
        tx_busy = (busy_left > 0);
      end
    end
  end

  // Reference model: frame bookkeeping at transaction granularity
  logic       m_act, m_launch, m_ackd, m_err, m_lock;
  int         m_wait, m_gid, mw;
  logic [7:0] m_data;

  function automatic int pick();
    int idx;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (m_gid + off) % NUM_REQ;
      if (req_valid[idx] && (!m_lock || idx == m_gid)) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_launch = 0; m_ackd = 0; m_wait = 0;
      m_data = 8'h00; m_gid = NUM_REQ - 1; m_err = 0; m_lock = 0;
    end else if (!m_act) begin
      mw = pick();
      if (!tx_busy && mw >= 0) begin
        m_data = req_data[8*mw +: 8];
        m_gid = mw;
        m_act = 1;
        m_launch = 1;
`ifdef UART_ARB_LOCK_EN
        m_lock = !req_last[mw];
`endif
      end
    end else if (m_launch) begin
      m_launch = 0; m_ackd = 0; m_wait = 0;
    end else if (!m_ackd) begin
      if (tx_busy) m_ackd = 1;
      else begin
        m_wait++;
        if (m_wait == ACK_TIMEOUT) begin
          m_err = 1; m_act = 0; m_lock = 0;
        end
      end
    end else if (!tx_busy) begin
      m_act = 0;
    end
  end

  // Per-cycle compare plus launch log
  int         cyc = 0;
  int         rdy2_cnt = 0;
  int         err_cyc = -1;
  int         log_n = 0;
  logic [7:0] log_data [64];
  int         log_gid [64];
  int         log_cyc [64];

  initial forever begin
    logic [3:0] exp_rdy;
    int         pw;
    @(negedge clk);
    cyc++;
    exp_rdy = '0;
    if (rst_n && !m_act && !tx_busy) begin
      pw = pick();
      if (pw >= 0) exp_rdy[pw] = 1'b1;
    end
    check("req_ready", req_ready, exp_rdy);
    check("tx_start", tx_start, m_launch);
    check("tx_data", tx_data, m_data);
    check("grant_id", grant_id, m_gid);
    check("active", active, m_act);
    check("err_timeout", err_timeout, m_err);
    if (req_ready[2]) rdy2_cnt++;
    if (tx_start && log_n < 64) begin
      log_data[log_n] = tx_data;
      log_gid[log_n]  = grant_id;
      log_cyc[log_n]  = cyc;
      log_n++;
    end
    if (err_timeout && err_cyc < 0) err_cyc = cyc;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int  n = 0;
    bit  done = 0;
    bit  empty;
    while (!done && n < 3000) begin
      tick(1);
      n++;
      empty = 1;
      for (int i = 0; i < 4; i++) if (shead[i] != stail[i]) empty = 0;
      if (empty && !active && !tx_busy && req_valid == '0) done = 1;
    end
    check("idle_reached", done, 1);
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int base, r0, n;
    bit found;
    logic [7:0] exp_b [8];
    rst_n = 1'b0;
    tick(3);
    check("reset_ready", req_ready, 0);
    check("reset_grant", grant_id, 3);
    check("reset_data", tx_data, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // Single requester 2
    busy_len = 100;
    r0 = rdy2_cnt;
    base = log_n;
    push(2, {1'b1, 8'h41});
    wait_idle();
    check("t1_ready_cycles", rdy2_cnt - r0, 1);
    check("t1_count", log_n - base, 1);
    check("t1_data", log_data[base], 8'h41);
    check("t1_gid", log_gid[base], 2);

    // All four continuously valid from reset
    busy_len = 3;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) push(i, {1'b1, 8'hA0 + 8'(i)});
    tick(2);
    base = log_n;
    rst_n = 1'b1;
    wait_idle();
    for (int k = 0; k < 8; k++) begin
      check("t2_data", log_data[base+k], 8'hA0 + 8'(k % 4));
      check("t2_gid", log_gid[base+k], k % 4);
    end

    // Busy held high while requests arrive
    busy_override = 1'b1;
    busy_force = 1'b1;
    tick(3);
    base = log_n;
    push(0, {1'b1, 8'h55});
    push(1, {1'b1, 8'h66});
    tick(6);
    check("t3_blocked", log_n - base, 0);
    busy_override = 1'b0;
    wait_idle();
    check("t3_data0", log_data[base], 8'h55);
    check("t3_gid0", log_gid[base], 0);
    check("t3_data1", log_data[base+1], 8'h66);
    check("t3_gid1", log_gid[base+1], 1);

    // Busy never rises: timeout then next request
    busy_len = 0;
    base = log_n;
    push(2, {1'b1, 8'h77});
    push(3, {1'b1, 8'h88});
    wait_idle();
    check("t4_data0", log_data[base], 8'h77);
    check("t4_data1", log_data[base+1], 8'h88);
    check("t4_gid1", log_gid[base+1], 3);
    check("t4_err_delay", err_cyc - log_cyc[base], ACK_TIMEOUT + 1);
    check("t4_err_sticky", err_timeout, 1);

    // Reset during WAIT_DONE
    busy_len = 50;
    push(1, {1'b1, 8'h99});
    n = 0; found = 0;
    while (!found && n < 500) begin
      tick(1); n++;
      if (tx_busy && active) found = 1;
    end
    check("t5_reached_busy", found, 1);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("t5_tx_start", tx_start, 0);
    check("t5_active", active, 0);
    check("t5_grant", grant_id, 3);
    check("t5_err", err_timeout, 0);
    check("t5_ready", req_ready, 0);
    busy_len = 3;
    push(1, {1'b1, 8'h11});
    push(0, {1'b1, 8'h10});
    tick(2);
    base = log_n;
    rst_n = 1'b1;
    wait_idle();
    check("t5_first_data", log_data[base], 8'h10);
    check("t5_first_gid", log_gid[base], 0);
    check("t5_second_data", log_data[base+1], 8'h11);

`ifdef UART_ARB_LOCK_EN
    // Locked burst from requester 1 while requester 2 waits
    push(3, {1'b1, 8'h30});
    wait_idle();
    base = log_n;
    push(1, {1'b0, 8'hB1});
    push(1, {1'b0, 8'hB2});
    push(1, {1'b1, 8'hB3});
    push(2, {1'b1, 8'hC1});
    wait_idle();
    exp_b[0] = 8'hB1; exp_b[1] = 8'hB2; exp_b[2] = 8'hB3; exp_b[3] = 8'hC1;
    for (int k = 0; k < 4; k++) check("t6_order", log_data[base+k], exp_b[k]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART byte transmitter among NUM_REQ byte sources. It accepts one byte at a time from the winning requester over a valid/ready handshake. It launches the byte into the transmitter with a one-cycle start pulse, then tracks the transmitter's busy flag until the frame completes. It sits between the system's byte producers (status/log/debug sources) and the transmitter on the 50 MHz clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ACK_TIMEOUT, 16, max cycles to wait for tx_busy to rise after a start pulse
TO_WIDTH, 5, width of the timeout counter; must hold ACK_TIMEOUT

Ports:
clk_50m  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  8*NUM_REQ  per-requester byte; requester i on bits [8*i+7:8*i]
req_ready  output  NUM_REQ  per-requester accept; byte transfers when valid and ready are both high in a cycle
tx_start  output  1  one-cycle launch pulse to the transmitter
tx_data  output  8  byte presented to the transmitter; stable from tx_start until the frame completes
tx_busy  input  1  transmitter busy flag
grant_id  output  $clog2(NUM_REQ)  index of the last accepted requester
active  output  1  high from acceptance until the frame completes
err_timeout  output  1  sticky flag: tx_busy never rose after a launch

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, tx_start=0, tx_data=8'h00, grant_id=NUM_REQ-1, active=0, err_timeout=0, timeout counter=0. req_ready is forced to 0 while in reset. Requester 0 has first priority after reset.
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
- Winner is combinational: the first i with req_valid[i]=1, scanning from (grant_id+1) mod NUM_REQ upward with wrap.
- req_ready is combinational: req_ready[winner]=1 only when state=IDLE and tx_busy=0. All other bits are 0, so at most one bit is high.
- IDLE: if tx_busy=1, accept nothing, even with requests pending. If tx_busy=0 and any valid, at the edge:
  - tx_data <= winner's byte, grant_id <= winner
  - tx_start <= 1, active <= 1
  - state <= LAUNCH
- LAUNCH: exactly one cycle with tx_start=1. At the edge: tx_start <= 0, counter <= 0, state <= WAIT_ACK. Acceptance-to-tx_start latency is 1 cycle.
- WAIT_ACK: if tx_busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches ACK_TIMEOUT-1 with busy still low: err_timeout <= 1, active <= 0, state <= IDLE. The byte is dropped; no retry.
- WAIT_DONE: when tx_busy=0: active <= 0, state <= IDLE. The next acceptance can occur in the following cycle (one idle cycle minimum between frames).
- Fairness: after requester k is served, k has lowest priority. With all requesters continuously valid, service order is k+1, k+2, ... with wrap. No requester waits more than NUM_REQ-1 frames.
- A requester dropping valid before its handshake loses nothing and is skipped. req_data is sampled only on the accept edge.
- err_timeout clears only on reset.
- Reset mid-frame: all state returns to reset values immediately. Any byte in progress is abandoned; the transmitter is not signalled.

Optional Feature:
UART_ARB_LOCK_EN adds input port req_last (NUM_REQ bits, qualified with req_valid).
- When defined: after accepting a byte with req_last[i]=0, the grant locks to requester i. Only i may be accepted (other ready bits stay 0) until a byte with req_last[i]=1 is accepted, which releases the lock and resumes round-robin from i+1. Lock status is an internal flag, cleared by reset and by err_timeout.
- When not defined: no req_last port; every byte is arbitrated independently.

Test Plan:
- Single requester 2 sends 8'h41, tx_busy model rises 1 cycle after tx_start and holds 100 cycles -> req_ready[2] high 1 cycle, tx_start pulse next cycle with tx_data=8'h41, active high until busy falls, grant_id=2.
- All 4 requesters valid continuously from reset, bytes 8'hA0..8'hA3 -> tx_data sequence A0,A1,A2,A3,A0 and grant_id 0,1,2,3,0.
- tx_busy held high at the moment requests arrive -> req_ready stays 0 and no tx_start until busy falls, then acceptance in that cycle.
- tx_busy never rises after a launch -> err_timeout=1 exactly ACK_TIMEOUT cycles after WAIT_ACK entry, then the next pending request is accepted; the flag stays high.
- rst_n pulled low while in WAIT_DONE -> tx_start=0, active=0, grant_id=3 asynchronously; after release, requester 0 is served first.
- With UART_ARB_LOCK_EN, requester 1 sends 3 bytes (last on the third) while requester 2 is valid -> all three bytes from 1 go out before any byte from 2.
